input_fetch_controller: RTL
===========================

Name: input_fetch_controller

Overview:
- Data-side responder to main_controller's prepare/finish handshake.
- On data_prepare_i, latches the block geometry and input-depth index, then streams the block's input tiles from input SRAM, two addresses per cycle.
- Forwards returned tiles to the Winograd PE array and pulses loop_finished_o when the last tile has been delivered.
- Sits between main_controller, the dual-port input SRAM and the PE input registers.

Parameters:
- TILE_W, 288, width of one input tile word (6x6 x 8-bit).
- ADDR_W, 16, SRAM address width.
- MEM_DEPTH, 4096, number of valid SRAM words; used only by the optional bound check.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- data_prepare_i  in  1  level request from main_controller; high while it waits
- data_id_i  in  4  input-depth slice index
- block_width_i  in  8  tiles per row, 1..10
- block_height_i  in  8  tiles per column, 1..10
- size_type_i  in  1  kernel size type; latched and forwarded
- mem_addr1_o  out  ADDR_W  port-1 read address
- mem_addr2_o  out  ADDR_W  port-2 read address
- mem_ren1_o  out  1  port-1 read enable
- mem_ren2_o  out  1  port-2 read enable
- mem_rdata1_i  in  TILE_W  port-1 data, valid 1 cycle after ren1
- mem_rdata2_i  in  TILE_W  port-2 data, valid 1 cycle after ren2
- tile1_o  out  TILE_W  registered tile, port 1
- tile2_o  out  TILE_W  registered tile, port 2
- tile1_valid_o  out  1  tile1_o valid
- tile2_valid_o  out  1  tile2_o valid
- size_type_o  out  1  latched size_type
- loop_finished_o  out  1  one-cycle pulse, last tile delivered
- addr_err_o  out  1  sticky bound error (optional feature only)

Behaviour:
- Reset (async, high):
  - state=IDLE.
  - All addresses 0; all enables, valids, loop_finished_o and addr_err_o 0.
  - Tiles 0, size_type_o 0.
- Arithmetic, computed at latch time into 16-bit registers:
  - blk = width*height (16-bit).
  - base = blk*data_id.
  - last = base+blk-1.
  - No truncation below 16 bits.
- States:
  - IDLE: on data_prepare_i=1, latch width, height, id, size_type and compute base/last.
    - blk==0: go to DONE and pulse loop_finished_o next cycle.
    - Otherwise go to FETCH.
  - FETCH: each cycle issue addr1=ptr and addr2=ptr+1 with ren1=1. ptr starts at base.
    - ren2=1 only if ptr+1<=last; else addr2=16'hFFFF, ren2=0.
    - ptr += 2.
    - Go to DRAIN on the cycle issuing ptr+1>=last.
  - DRAIN: one cycle, no reads issued; the last read data returns.
  - DONE: hold outputs idle. Go to IDLE only once data_prepare_i=0. This re-arms on main_controller's COMPLETE cycle and prevents a double start.
- Data path:
  - tileN_o <= mem_rdataN_i and tileN_valid_o <= renN delayed 1 cycle.
  - Total latency from issue to valid output: 2 cycles.
- Handshake timing:
  - loop_finished_o is high exactly in the cycle the final tile valid is high, i.e. the cycle of the DRAIN→DONE transition's registered output.
  - Exactly one pulse per request.
- Inputs ignored outside IDLE. Mid-operation changes of geometry or id have no effect.
- data_prepare_i dropping during FETCH: ignored; the fetch completes.
- Reset mid-FETCH: immediate abort to IDLE; no loop_finished_o pulse.
- Odd blk: final cycle has a single port-1 read. Even blk: final cycle has both ports.
- No backpressure: the PE must accept every valid tile.

Optional Feature:
- Macro: ADDR_BOUND_CHECK_EN.
- Defined:
  - At latch, if last>=MEM_DEPTH, set addr_err_o (sticky until reset) and go to DONE with a loop_finished_o pulse; no reads are issued.
  - Any issued address >= MEM_DEPTH also sets addr_err_o.
- Undefined: addr_err_o tied 0; no comparison logic.

Decomposition:
- Shared package winocnn_pkg:
  - fetch_state_t enum {IDLE, FETCH, DRAIN, DONE}.
  - TILE_W and ADDR_W defaults.
  - Constant ADDR_NONE=16'hFFFF.
  - MAX_BLOCK_DIM=10.
- One natural sub-module: fetch_addr_gen, holding the ptr counter, last compare and odd-tail detection. The top keeps the FSM and data registers.

Test Plan:
- w=2,h=2,id=0, prepare high → (0,1),(2,3) with ren2=1 both cycles; four valid tiles; loop_finished_o 1 pulse aligned with the second output pair.
- w=3,h=1,id=2 → base 6: (6,7), then (8,FFFF) with ren2=0; final cycle tile1_valid_o=1, tile2_valid_o=0, loop_finished_o=1.
- Prepare held high after DONE → no second fetch. Drop prepare 1 cycle then raise with id=1 → fetch restarts at base=blk.
- Reset asserted during second FETCH cycle of w=10,h=10 → all outputs 0 the same cycle; no pulse; a new prepare starts cleanly at base.
- w=1,h=1,id=0 → single read (0,FFFF); loop_finished_o exactly 2 cycles after the read is issued.
- With ADDR_BOUND_CHECK_EN and MEM_DEPTH=64: w=10,h=10,id=0 → addr_err_o=1, no ren pulses, one loop_finished_o pulse.

Source files
------------

// File: rtl/winocnn_pkg.sv
// Shared types and constants for the Winograd CNN accelerator blocks.
package winocnn_pkg;

    localparam int TILE_W_DEF    = 288;
    localparam int ADDR_W_DEF    = 16;
    localparam int MEM_DEPTH_DEF = 4096;
    localparam int MAX_BLOCK_DIM = 10;

    localparam logic [15:0] ADDR_NONE = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } fetch_state_t;

endpackage

// File: rtl/fetch_addr_gen.sv
// Read-pointer generator for input_fetch_controller: produces the address pair
// for the current issue cycle, the port-2 enable for odd tails and the final-pair flag.
module fetch_addr_gen
    import winocnn_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_last,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_addr1,
    output logic [ADDR_W-1:0] o_addr2,
    output logic              o_ren2,
    output logic              o_final
);

    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_cur;
    logic [ADDR_W-1:0] w_next1;

    // While idle the pair is taken straight from the fresh base so the first read issues on entry to FETCH.
    assign w_cur   = i_load ? i_base : r_ptr;
    assign w_next1 = w_cur + ADDR_W'(1);
    assign o_addr1 = w_cur;
    assign o_ren2  = (w_next1 <= i_last);
    assign o_addr2 = o_ren2 ? w_next1 : ADDR_W'(ADDR_NONE);
    assign o_final = (w_next1 >= i_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_step) begin
            r_ptr <= w_cur + ADDR_W'(2);
        end
    end

endmodule

// File: rtl/input_fetch_controller.sv
// Streams one block of input tiles from the dual-port input SRAM to the PE array.
// Optional macro ADDR_BOUND_CHECK_EN adds a sticky out-of-range address check.
module input_fetch_controller
    import winocnn_pkg::*;
#(
    parameter int TILE_W = TILE_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
`ifdef ADDR_BOUND_CHECK_EN
    , parameter int MEM_DEPTH = MEM_DEPTH_DEF
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_prepare_i,
    input  logic [3:0]        data_id_i,
    input  logic [7:0]        block_width_i,
    input  logic [7:0]        block_height_i,
    input  logic              size_type_i,
    output logic [ADDR_W-1:0] mem_addr1_o,
    output logic [ADDR_W-1:0] mem_addr2_o,
    output logic              mem_ren1_o,
    output logic              mem_ren2_o,
    input  logic [TILE_W-1:0] mem_rdata1_i,
    input  logic [TILE_W-1:0] mem_rdata2_i,
    output logic [TILE_W-1:0] tile1_o,
    output logic [TILE_W-1:0] tile2_o,
    output logic              tile1_valid_o,
    output logic              tile2_valid_o,
    output logic              size_type_o,
    output logic              loop_finished_o,
    output logic              addr_err_o
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_last;
    logic              r_final;
    logic              r_size;
    logic              r_loop;
    logic [ADDR_W-1:0] r_addr1;
    logic [ADDR_W-1:0] r_addr2;
    logic              r_ren1;
    logic              r_ren2;
    logic              r_ren1_d;
    logic              r_ren2_d;
    logic              r_valid1;
    logic              r_valid2;
    logic [TILE_W-1:0] r_tile1;
    logic [TILE_W-1:0] r_tile2;

    logic [ADDR_W-1:0] w_blk;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_last;
    logic [ADDR_W-1:0] w_gen_last;
    logic [ADDR_W-1:0] w_addr1;
    logic [ADDR_W-1:0] w_addr2;
    logic              w_ren2;
    logic              w_final;
    logic              w_start;
    logic              w_blk_zero;
    logic              w_bound_err;
    logic              w_launch;
    logic              w_step;

    assign w_blk      = ADDR_W'(block_width_i) * ADDR_W'(block_height_i);
    assign w_base     = w_blk * ADDR_W'(data_id_i);
    assign w_last     = w_base + w_blk - ADDR_W'(1);
    assign w_start    = (r_state == IDLE) && data_prepare_i;
    assign w_blk_zero = (w_blk == '0);

`ifdef ADDR_BOUND_CHECK_EN
    assign w_bound_err = (32'(w_last) >= 32'(MEM_DEPTH));
`else
    assign w_bound_err = 1'b0;
`endif

    assign w_launch   = w_start && !w_blk_zero && !w_bound_err;
    assign w_step     = w_launch || ((r_state == FETCH) && !r_final);
    assign w_gen_last = (r_state == IDLE) ? w_last : r_last;

    fetch_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .i_load  (r_state == IDLE),
        .i_base  (w_base),
        .i_last  (w_gen_last),
        .i_step  (w_step),
        .o_addr1 (w_addr1),
        .o_addr2 (w_addr2),
        .o_ren2  (w_ren2),
        .o_final (w_final)
    );

    // DONE waits for prepare to drop so a request held high cannot start a second fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_last  <= '0;
            r_final <= 1'b0;
            r_size  <= 1'b0;
            r_loop  <= 1'b0;
            r_addr1 <= '0;
            r_addr2 <= '0;
            r_ren1  <= 1'b0;
            r_ren2  <= 1'b0;
        end else begin
            r_loop  <= 1'b0;
            r_addr1 <= '0;
            r_addr2 <= '0;
            r_ren1  <= 1'b0;
            r_ren2  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (data_prepare_i) begin
                        r_size <= size_type_i;
                        r_last <= w_last;
                        if (w_launch) begin
                            r_state <= FETCH;
                            r_addr1 <= w_addr1;
                            r_addr2 <= w_addr2;
                            r_ren1  <= 1'b1;
                            r_ren2  <= w_ren2;
                            r_final <= w_final;
                        end else begin
                            r_state <= DONE;
                            r_loop  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (r_final) begin
                        r_state <= DRAIN;
                    end else begin
                        r_addr1 <= w_addr1;
                        r_addr2 <= w_addr2;
                        r_ren1  <= 1'b1;
                        r_ren2  <= w_ren2;
                        r_final <= w_final;
                    end
                end
                DRAIN: begin
                    r_state <= DONE;
                    r_loop  <= 1'b1;
                end
                DONE: begin
                    if (!data_prepare_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // SRAM data lands one cycle after the read; register it once more for the PE inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ren1_d <= 1'b0;
            r_ren2_d <= 1'b0;
            r_valid1 <= 1'b0;
            r_valid2 <= 1'b0;
            r_tile1  <= '0;
            r_tile2  <= '0;
        end else begin
            r_ren1_d <= r_ren1;
            r_ren2_d <= r_ren2;
            r_valid1 <= r_ren1_d;
            r_valid2 <= r_ren2_d;
            r_tile1  <= mem_rdata1_i;
            r_tile2  <= mem_rdata2_i;
        end
    end

`ifdef ADDR_BOUND_CHECK_EN
    logic r_addr_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr_err <= 1'b0;
        end else if ((w_start && !w_blk_zero && w_bound_err) ||
                     (r_ren1 && (32'(r_addr1) >= 32'(MEM_DEPTH))) ||
                     (r_ren2 && (32'(r_addr2) >= 32'(MEM_DEPTH)))) begin
            r_addr_err <= 1'b1;
        end
    end

    assign addr_err_o = r_addr_err;
`else
    assign addr_err_o = 1'b0;
`endif

    assign mem_addr1_o     = r_addr1;
    assign mem_addr2_o     = r_addr2;
    assign mem_ren1_o      = r_ren1;
    assign mem_ren2_o      = r_ren2;
    assign tile1_o         = r_tile1;
    assign tile2_o         = r_tile2;
    assign tile1_valid_o   = r_valid1;
    assign tile2_valid_o   = r_valid2;
    assign size_type_o     = r_size;
    assign loop_finished_o = r_loop;

endmodule
